// File: rtl/fdiv_sched.sv
// Round-robin scheduler sharing one pipelined fdiv between NREQ requesters.
// Optional divide-by-zero short path enabled by defining FDIV_SCHED_DZ_EN.
module fdiv_sched #(
  parameter int NREQ    = 2,
  parameter int DIV_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_op1,
  input  logic [32*NREQ-1:0]   req_op2,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [32*NREQ-1:0]   rsp_data,
  output logic [31:0]          div_op1,
  output logic [31:0]          div_op2,
  input  logic [31:0]          div_result,
  output logic                 idle
);

  localparam int unsigned N  = NREQ;
  localparam int unsigned IW = (NREQ > 2) ? 2 : 1;

  logic [NREQ-1:0]            r_busy;
  logic [IW-1:0]              r_rr;
  logic [31:0]                r_div_op1;
  logic [31:0]                r_div_op2;
  logic [DIV_LAT:0]           r_tag_v;
  logic [DIV_LAT:0][IW-1:0]   r_tag_i;
  logic [NREQ-1:0]            r_rsp_valid;
  logic [NREQ-1:0][31:0]      r_rsp_data;

  logic [NREQ-1:0]            w_elig;
  logic [NREQ-1:0]            w_grant;
  logic [NREQ-1:0]            w_cap;
  logic                       w_found;
  logic [IW-1:0]              w_gnt_idx;
  logic [31:0]                w_op1;
  logic [31:0]                w_op2;
  logic                       w_issue;
  logic                       w_dz;

  function automatic logic [IW-1:0] f_wrap(input logic [IW-1:0] base, input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  assign w_elig = req_valid & ~r_busy;

  // Scan from the priority pointer upward; the first eligible requester wins.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_grant   = '0;
    w_op1     = '0;
    w_op2     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!w_found && w_elig[f_wrap(r_rr, k)]) begin
        w_found   = 1'b1;
        w_gnt_idx = f_wrap(r_rr, k);
      end
    end
    for (int unsigned k = 0; k < N; k++) begin
      if (w_found && w_gnt_idx == IW'(k)) begin
        w_grant[k] = 1'b1;
        w_op1      = req_op1[32*k +: 32];
        w_op2      = req_op2[32*k +: 32];
      end
    end
  end

`ifdef FDIV_SCHED_DZ_EN
  logic            r_dz_v;
  logic [IW-1:0]   r_dz_i;
  logic [31:0]     r_dz_data;
  logic [NREQ-1:0] w_dzcap;

  assign w_dz = w_found && (w_op2[30:0] == '0);

  always_comb begin
    w_dzcap = '0;
    for (int unsigned k = 0; k < N; k++)
      if (r_dz_v && r_dz_i == IW'(k)) w_dzcap[k] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_dz_v    <= 1'b0;
      r_dz_i    <= '0;
      r_dz_data <= '0;
    end else begin
      r_dz_v    <= w_dz;
      r_dz_i    <= w_gnt_idx;
      r_dz_data <= {w_op1[31] ^ w_op2[31], 8'hFF, 23'h0};
    end
  end
`else
  assign w_dz = 1'b0;
`endif

  assign w_issue = w_found & ~w_dz;

  always_comb begin
    w_cap = '0;
    for (int unsigned k = 0; k < N; k++)
      if (r_tag_v[DIV_LAT] && r_tag_i[DIV_LAT] == IW'(k)) w_cap[k] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_busy      <= '0;
      r_rr        <= '0;
      r_div_op1   <= '0;
      r_div_op2   <= '0;
      r_tag_v     <= '0;
      r_tag_i     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_found) r_rr <= f_wrap(w_gnt_idx, 1);
      if (w_issue) begin
        r_div_op1 <= w_op1;
        r_div_op2 <= w_op2;
      end
      r_tag_v <= {r_tag_v[DIV_LAT-1:0], w_issue};
      r_tag_i <= {r_tag_i[DIV_LAT-1:0], w_gnt_idx};
      for (int unsigned i = 0; i < N; i++) begin
        if (w_grant[i])
          r_busy[i] <= 1'b1;
        else if (r_rsp_valid[i] && rsp_ready[i])
          r_busy[i] <= 1'b0;

        if (w_cap[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= div_result;
        end
`ifdef FDIV_SCHED_DZ_EN
        else if (w_dzcap[i]) begin
          r_rsp_valid[i] <= 1'b1;
          r_rsp_data[i]  <= r_dz_data;
        end
`endif
        else if (rsp_ready[i]) begin
          r_rsp_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign div_op1   = r_div_op1;
  assign div_op2   = r_div_op2;
`ifdef FDIV_SCHED_DZ_EN
  assign idle = ~(|r_busy) & ~(|r_tag_v) & ~r_dz_v;
`else
  assign idle = ~(|r_busy) & ~(|r_tag_v);
`endif

endmodule

// File: tb/tb_fdiv_sched.sv
// Directed self-checking bench for fdiv_sched (NREQ=2, DIV_LAT=2).
// The divider stand-in returns op1-op2 after two register stages.
module tb_fdiv_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_op1;
  logic [63:0] req_op2;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [63:0] rsp_data;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic [31:0] div_result;
  logic        idle;

  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    m_a <= div_op1 - div_op2;
    m_b <= m_a;
  end
  assign div_result = m_b;

  fdiv_sched #(.NREQ(2), .DIV_LAT(2)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .div_op1(div_op1), .div_op2(div_op2), .div_result(div_result),
    .idle(idle)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; req_valid = '0; rsp_ready = '0; req_op1 = '0; req_op2 = '0;
    next_cycle();
    next_cycle();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got %b exp 00", rsp_valid); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle got %b exp 1", idle); end
    tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got %b exp 00", req_ready); end
    tests++; if ({div_op1, div_op2} !== 64'h0) begin fails++; $display("FAIL reset_div_ops got %h exp 0", {div_op1, div_op2}); end
    next_cycle();
  endtask

  task automatic test_single();
    logic [1:0] exp_rv;
    do_reset();
    req_valid = 2'b01; req_op1[31:0] = 32'h40400000; req_op2[31:0] = 32'h40000000;
    @(negedge clk);
    tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL single_grant got %b exp 01", req_ready); end
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    tests++; if (div_op1 !== 32'h40400000) begin fails++; $display("FAIL single_div_op1 got %h exp 40400000", div_op1); end
    tests++; if (div_op2 !== 32'h40000000) begin fails++; $display("FAIL single_div_op2 got %h exp 40000000", div_op2); end
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL single_idle_busy got %b exp 0", idle); end
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      exp_rv = (c == 4) ? 2'b01 : 2'b00;
      tests++; if (rsp_valid !== exp_rv) begin fails++; $display("FAIL single_rsp_valid_T%0d got %b exp %b", c, rsp_valid, exp_rv); end
    end
    tests++; if (rsp_data[31:0] !== 32'h00400000) begin fails++; $display("FAIL single_rsp_data got %h exp 00400000", rsp_data[31:0]); end
    next_cycle();
    rsp_ready = 2'b01;
    next_cycle();
    rsp_ready = 2'b00;
    @(negedge clk);
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL single_consumed got %b exp 00", rsp_valid); end
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL single_idle_after got %b exp 1", idle); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    do_reset();
    req_op1 = {32'h00000100, 32'h00000010};
    req_op2 = {32'h00000001, 32'h00000003};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      exp_rdy = (k % 5 == 0) ? 2'b01 : (k % 5 == 1) ? 2'b10 : 2'b00;
      exp_rv  = (k % 5 == 4) ? 2'b01 : (k % 5 == 0 && k > 0) ? 2'b10 : 2'b00;
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL rr_grant_c%0d got %b exp %b", k, req_ready, exp_rdy); end
      tests++; if (rsp_valid !== exp_rv) begin fails++; $display("FAIL rr_rsp_valid_c%0d got %b exp %b", k, rsp_valid, exp_rv); end
      if (exp_rv[0]) begin
        tests++; if (rsp_data[31:0] !== 32'h0000000D) begin fails++; $display("FAIL rr_data0_c%0d got %h exp 0000000d", k, rsp_data[31:0]); end
      end
      if (exp_rv[1]) begin
        tests++; if (rsp_data[63:32] !== 32'h000000FF) begin fails++; $display("FAIL rr_data1_c%0d got %h exp 000000ff", k, rsp_data[63:32]); end
      end
      next_cycle();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_busy_block();
    logic [1:0] exp_rdy;
    logic [1:0] exp_rv;
    do_reset();
    req_op1 = {32'h00000100, 32'h40400000};
    req_op2 = {32'h00000001, 32'h40000000};
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      rsp_ready = {1'b1, (k == 14)};
      @(negedge clk);
      exp_rdy = (k == 0 || k == 15) ? 2'b01 : (k % 5 == 1) ? 2'b10 : 2'b00;
      exp_rv  = {(k % 5 == 0 && k > 0), (k >= 4 && k <= 14)};
      tests++; if (req_ready !== exp_rdy) begin fails++; $display("FAIL busy_grant_c%0d got %b exp %b", k, req_ready, exp_rdy); end
      tests++; if (rsp_valid !== exp_rv) begin fails++; $display("FAIL busy_rsp_valid_c%0d got %b exp %b", k, rsp_valid, exp_rv); end
      if (exp_rv[0]) begin
        tests++; if (rsp_data[31:0] !== 32'h00400000) begin fails++; $display("FAIL busy_data0_c%0d got %h exp 00400000", k, rsp_data[31:0]); end
      end
      next_cycle();
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 2'b01; req_op1[31:0] = 32'h3F800000; req_op2[31:0] = 32'h3F000000;
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
    tests++; if (idle !== 1'b0) begin fails++; $display("FAIL midrst_idle_before got %b exp 0", idle); end
    next_cycle();
    rstn = 1'b0;
    next_cycle();
    rstn = 1'b1;
    @(negedge clk);
    tests++; if (idle !== 1'b1) begin fails++; $display("FAIL midrst_idle got %b exp 1", idle); end
    tests++; if (div_op1 !== 32'h0) begin fails++; $display("FAIL midrst_div_op1 got %h exp 0", div_op1); end
    for (int k = 0; k < 6; k++) begin
      tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL midrst_rsp_valid_c%0d got %b exp 00", k, rsp_valid); end
      next_cycle();
      @(negedge clk);
    end
  endtask

  task automatic test_div_zero();
    do_reset();
    req_valid = 2'b01; req_op1[31:0] = 32'hC0000000; req_op2[31:0] = 32'h80000000;
    next_cycle();
    req_valid = 2'b00;
    @(negedge clk);
`ifdef FDIV_SCHED_DZ_EN
    tests++; if (div_op1 !== 32'h0) begin fails++; $display("FAIL dz_div_op1_held got %h exp 0", div_op1); end
    tests++; if (rsp_valid !== 2'b00) begin fails++; $display("FAIL dz_rsp_valid_T1 got %b exp 00", rsp_valid); end
    next_cycle();
    @(negedge clk);
    tests++; if (rsp_valid !== 2'b01) begin fails++; $display("FAIL dz_rsp_valid_T2 got %b exp 01", rsp_valid); end
    tests++; if (rsp_data[31:0] !== 32'h7F800000) begin fails++; $display("FAIL dz_rsp_data got %h exp 7f800000", rsp_data[31:0]); end
`else
    tests++; if (div_op1 !== 32'hC0000000) begin fails++; $display("FAIL nodz_div_op1 got %h exp c0000000", div_op1); end
    for (int c = 2; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      tests++; if (rsp_valid !== ((c == 4) ? 2'b01 : 2'b00)) begin fails++; $display("FAIL nodz_rsp_valid_T%0d got %b exp %b", c, rsp_valid, (c == 4) ? 2'b01 : 2'b00); end
    end
    tests++; if (rsp_data[31:0] !== 32'h40000000) begin fails++; $display("FAIL nodz_rsp_data got %h exp 40000000", rsp_data[31:0]); end
`endif
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_block();
    test_reset_mid();
    test_div_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
